pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_types_pkg.sv | 54 +++++
 rtl/hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: FSM states, hazard conditions, stage control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

    localparam int REG_IDX_W = 5;

    // Number of cycles the back end keeps advancing after HALT leaves EX.
    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    // Per-cycle pipeline condition, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        C_ADVANCE  = 3'd0,
        C_IWAIT    = 3'd1,
        C_LOADUSE  = 3'd2,
        C_REDIRECT = 3'd3,
        C_DRAIN    = 3'd4,
        C_MEMWAIT  = 3'd5,
        C_HALTED   = 3'd6
    } pipe_cond_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
    };

    localparam stage_ctrl_t CTRL_FROZEN = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0
    };

    // Saturating 16-bit increment for the stall counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and control-flow redirect detection between the ID and EX stages.
// Latency: purely combinational, zero cycles.
// Backpressure: none; results are consumed by pipeline_ctrl in the same cycle.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic                 ex_memRead,
    input  logic [REG_IDX_W-1:0] ex_regSel,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_usesRt,
    input  logic                 ex_branchSel,
    input  logic [1:0]           ex_jump,
    output logic                 load_use,
    output logic                 redirect
);

    // Load in EX whose destination feeds an ID source; r0 never creates a dependency.
    always_comb begin
        load_use = ex_memRead
                && (ex_regSel != '0)
                && ((ex_regSel == id_rs) || (id_usesRt && (ex_regSel == id_rt)));
        redirect = ex_branchSel || (ex_jump != 2'b00);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with RUN/DRAIN/HALTED FSM and saturating stall counter.
// Latency: enables/flushes combinational from inputs and state; state and counters update next edge.
// Backpressure: data-cache miss freezes the front end and EX/MEM; I-miss and load-use stall the PC.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ex_memRead,
    input  logic [REG_IDX_W-1:0] ex_regSel,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_usesRt,
    input  logic                 ex_branchSel,
    input  logic [1:0]           ex_jump,
    input  logic                 ex_halt,
    input  logic                 mem_req,
    input  logic                 dhit,
    input  logic                 ihit,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_flush,
    output logic                 halted,
    output logic [15:0]          stall_cnt
);

    pipe_state_t state, state_nxt, eff_state;
    logic [1:0]  drain_cnt, drain_cnt_nxt;
    logic        memwait, load_use, redirect, drain_active, count_stall;
    pipe_cond_t  cond;
    stage_ctrl_t ctrl;

    hazard_detect u_hazard (
        .ex_memRead   (ex_memRead),
        .ex_regSel    (ex_regSel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_usesRt    (id_usesRt),
        .ex_branchSel (ex_branchSel),
        .ex_jump      (ex_jump),
        .load_use     (load_use),
        .redirect     (redirect)
    );

    // Pick the single highest-priority condition; reset decodes as RUN.
    always_comb begin
        eff_state    = RST ? RUN : state;
        memwait      = mem_req && !dhit;
        drain_active = (eff_state == DRAIN) || ((eff_state == RUN) && ex_halt);
        cond         = C_ADVANCE;
        if (eff_state == HALTED)  cond = C_HALTED;
        else if (memwait)         cond = C_MEMWAIT;
        else if (drain_active)    cond = C_DRAIN;
        else if (redirect)        cond = C_REDIRECT;
        else if (load_use)        cond = C_LOADUSE;
        else if (!ihit)           cond = C_IWAIT;
    end

    // Decode the condition into stage enables and bubble-insert flushes.
    always_comb begin
        ctrl = CTRL_ADVANCE;
        unique case (cond)
            C_HALTED: ctrl = CTRL_FROZEN;
            C_MEMWAIT: begin
                ctrl             = CTRL_FROZEN;
                ctrl.memwb_en    = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end
            C_DRAIN: begin
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end
            C_REDIRECT: begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end
            C_LOADUSE: begin
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_en    = 1'b0;
                ctrl.idex_flush = 1'b1;
            end
            C_IWAIT: begin
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_flush = 1'b1;
            end
            default: ctrl = CTRL_ADVANCE;
        endcase
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign halted      = (eff_state == HALTED);
    assign count_stall = (eff_state != HALTED) && !ctrl.pc_en;

    // Next-state: enter DRAIN on HALT, count down on non-MEMWAIT cycles, stop at zero.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        unique case (state)
            RUN: begin
                if (ex_halt && !memwait) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_CYCLES;
                end
            end
            DRAIN: begin
                if (!memwait) begin
                    if (drain_cnt <= 2'd1) begin
                        drain_cnt_nxt = 2'd0;
                        state_nxt     = HALTED;
                    end else begin
                        drain_cnt_nxt = drain_cnt - 2'd1;
                    end
                end
            end
            HALTED: state_nxt = HALTED;
            default: begin
                state_nxt     = RUN;
                drain_cnt_nxt = 2'd0;
            end
        endcase
    end

    // State, drain counter and stall counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (count_stall) begin
                stall_cnt <= sat_inc16(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard priorities, drain/halt sequence, reset and stall-counter saturation.
// Latency: inputs driven at falling edge, outputs sampled 1ns later, registers checked the following cycle.
// Backpressure: exercised through mem_req/dhit and ihit stimulus.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_memRead;
    logic [4:0]  ex_regSel, id_rs, id_rt;
    logic        id_usesRt, ex_branchSel;
    logic [1:0]  ex_jump;
    logic        ex_halt, mem_req, dhit, ihit;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_flush, halted;
    logic [15:0] stall_cnt;
    logic [7:0]  ctrl_obs;

    int vectors    = 0;
    int miscompares = 0;

    // Expected control bundles {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes} and care masks.
    localparam logic [7:0] E_ADV = 8'hF8, M_ALL = 8'hFF;
    localparam logic [7:0] E_MW  = 8'h09;
    localparam logic [7:0] E_RD  = 8'h9E, M_RD = 8'h9F;
    localparam logic [7:0] E_LU  = 8'h1A, M_LU = 8'hDF;
    localparam logic [7:0] E_IW  = 8'h3C, M_IW = 8'hBF;
    localparam logic [7:0] E_DR  = 8'h1E, M_DR = 8'h9F;
    localparam logic [7:0] E_HLT = 8'h00;

    always #5 CLK = ~CLK;

    assign ctrl_obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush};

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST),
        .ex_memRead(ex_memRead), .ex_regSel(ex_regSel), .id_rs(id_rs), .id_rt(id_rt),
        .id_usesRt(id_usesRt), .ex_branchSel(ex_branchSel), .ex_jump(ex_jump),
        .ex_halt(ex_halt), .mem_req(mem_req), .dhit(dhit), .ihit(ihit),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    task automatic idle();
        ex_memRead = 1'b0; ex_regSel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_usesRt = 1'b0;
        ex_branchSel = 1'b0; ex_jump = 2'b00; ex_halt = 1'b0; mem_req = 1'b0; dhit = 1'b1; ihit = 1'b1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [7:0] exp, input logic [7:0] mask);
        vectors++;
        assert ((ctrl_obs & mask) === (exp & mask))
        else begin
            miscompares++;
            $error("FAIL %s ctrl observed=%b expected=%b mask=%b", tag, ctrl_obs, exp, mask);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [7:0] e, input logic [7:0] m,
                             input logic [15:0] e_stall, input logic e_halted);
        #1;
        chk_ctrl(tag, e, m);
        chk16({tag, "_stall"}, stall_cnt, e_stall);
        chk16({tag, "_halted"}, {15'd0, halted}, {15'd0, e_halted});
    endtask

    initial begin
        RST = 1'b1;
        idle();
        @(negedge CLK); chk_cycle("reset", E_ADV, M_ALL, 16'd0, 1'b0);

        @(negedge CLK); RST = 1'b0; idle();
        chk_cycle("advance", E_ADV, M_ALL, 16'd0, 1'b0);

        // Load-use on rs: one stall cycle, then the load has moved on.
        @(negedge CLK); idle(); ex_memRead = 1'b1; ex_regSel = 5'd5; id_rs = 5'd5;
        chk_cycle("loaduse_rs", E_LU, M_LU, 16'd0, 1'b0);
        @(negedge CLK); idle();
        chk_cycle("after_loaduse", E_ADV, M_ALL, 16'd1, 1'b0);

        // r0 destination never stalls.
        @(negedge CLK); idle(); ex_memRead = 1'b1;
        chk_cycle("r0_no_stall", E_ADV, M_ALL, 16'd1, 1'b0);

        // rt match only counts when ID actually reads rt.
        @(negedge CLK); idle(); ex_memRead = 1'b1; ex_regSel = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
        chk_cycle("rt_unused", E_ADV, M_ALL, 16'd1, 1'b0);
        @(negedge CLK); id_usesRt = 1'b1;
        chk_cycle("loaduse_rt", E_LU, M_LU, 16'd1, 1'b0);

        // Redirect beats load-use.
        @(negedge CLK); idle(); ex_memRead = 1'b1; ex_regSel = 5'd5; id_rs = 5'd5; ex_branchSel = 1'b1;
        chk_cycle("redirect_over_lu", E_RD, M_RD, 16'd2, 1'b0);
        @(negedge CLK); idle(); ex_jump = 2'b01;
        chk_cycle("jump", E_RD, M_RD, 16'd2, 1'b0);

        // D-miss holds off the pending branch for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); idle(); mem_req = 1'b1; dhit = 1'b0; ex_branchSel = 1'b1;
            chk_cycle("memwait", E_MW, M_ALL, 16'(2 + i), 1'b0);
        end
        @(negedge CLK); dhit = 1'b1;
        chk_cycle("redirect_after_hit", E_RD, M_RD, 16'd5, 1'b0);

        @(negedge CLK); idle(); ihit = 1'b0;
        chk_cycle("iwait", E_IW, M_IW, 16'd5, 1'b0);

        // HALT with one D-miss inside DRAIN: HALTED after four edges.
        @(negedge CLK); idle(); ex_halt = 1'b1;
        chk_cycle("halt_enter", E_DR, M_DR, 16'd6, 1'b0);
        @(negedge CLK); idle();
        chk_cycle("drain_1", E_DR, M_DR, 16'd7, 1'b0);
        @(negedge CLK); idle(); mem_req = 1'b1; dhit = 1'b0;
        chk_cycle("drain_memwait", E_MW, M_ALL, 16'd8, 1'b0);
        @(negedge CLK); idle();
        chk_cycle("drain_2", E_DR, M_DR, 16'd9, 1'b0);
        @(negedge CLK); idle(); ihit = 1'b0; ex_memRead = 1'b1; ex_regSel = 5'd4; id_rs = 5'd4;
        chk_cycle("halted_1", E_HLT, M_ALL, 16'd10, 1'b1);
        @(negedge CLK); idle();
        chk_cycle("halted_2", E_HLT, M_ALL, 16'd10, 1'b1);

        // Reset out of HALTED decodes as RUN during the reset cycle.
        @(negedge CLK); RST = 1'b1; idle();
        chk_cycle("rst_in_halted", E_ADV, M_ALL, 16'd10, 1'b0);
        @(negedge CLK); RST = 1'b0;
        chk_cycle("run_after_rst", E_ADV, M_ALL, 16'd0, 1'b0);

        // Reset in the middle of DRAIN.
        @(negedge CLK); idle(); ex_halt = 1'b1;
        chk_cycle("halt_again", E_DR, M_DR, 16'd0, 1'b0);
        @(negedge CLK); idle(); RST = 1'b1;
        chk_cycle("rst_in_drain", E_ADV, M_ALL, 16'd1, 1'b0);
        @(negedge CLK); RST = 1'b0;
        chk_cycle("run_after_drain_rst", E_ADV, M_ALL, 16'd0, 1'b0);

        // Hold an I-miss long enough to saturate the stall counter.
        @(negedge CLK); idle(); ihit = 1'b0;
        chk_cycle("sat_start", E_IW, M_IW, 16'd0, 1'b0);
        repeat (65535) @(negedge CLK);
        chk_cycle("sat_reached", E_IW, M_IW, 16'hFFFF, 1'b0);
        repeat (4) @(negedge CLK);
        chk_cycle("sat_held", E_IW, M_IW, 16'hFFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
